// File: rtl/hdmi_scanout.sv
// hdmi_scanout: 640x480 video timing generator and framebuffer scanout.
// Scans a half-resolution RGB565 framebuffer at 2x scale and emits RGB888
// with DE/hSync/vSync aligned to the pixel data through a fixed-depth pipeline.
module hdmi_scanout #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FRONT      = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BACK       = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33,
    parameter int unsigned FB_WIDTH     = 320,
    parameter int unsigned ADDR_WIDTH   = 17,
    parameter int unsigned FB_BASE0     = 0,
    parameter int unsigned FB_BASE1     = 76800,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fbHDMI,
    input  logic [15:0]           memData,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memRead,
    output logic [23:0]           rgb,
    output logic                  de,
    output logic                  hSync,
    output logic                  vSync,
    output logic                  frameStart
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    // Counter-to-pin latency: address register, memory latency, colour register.
    localparam int unsigned L       = READ_LATENCY + 2;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST_ACT = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic [ADDR_WIDTH-1:0] BASE0    = ADDR_WIDTH'(FB_BASE0);
    localparam logic [ADDR_WIDTH-1:0] BASE1    = ADDR_WIDTH'(FB_BASE1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH);

    logic [HW-1:0]         h_cnt_q, h_cnt_d;
    logic [VW-1:0]         v_cnt_q, v_cnt_d;
    logic                  fb_latched_q, fb_latched_d;
    logic [ADDR_WIDTH-1:0] row_off_q, row_off_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_read_q, mem_read_d;
    logic                  frame_start_q, frame_start_d;
    logic [23:0]           rgb_q, rgb_d;
    logic [L-1:0]          act_dly_q, act_dly_d;
    logic [L-1:0]          hs_dly_q, hs_dly_d;
    logic [L-1:0]          vs_dly_q, vs_dly_d;

    logic                  h_wrap, v_wrap;
    logic                  act, hs, vs;
    logic                  frame_top;
    logic                  fb_sel;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] row_off_cur;
    logic [ADDR_WIDTH-1:0] fetch_addr;

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Stage-0 region decode straight from the counters.
    always_comb begin
        act = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        hs  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    end

    // Fetch address: base + row offset + h/2. At (0,0) the select input is used
    // directly so the first fetch of a frame already sees the newly latched base.
    always_comb begin
        frame_top   = (h_cnt_q == '0) && (v_cnt_q == '0);
        fb_sel      = frame_top ? fbHDMI : fb_latched_q;
        base_addr   = fb_sel ? BASE1 : BASE0;
        row_off_cur = frame_top ? '0 : row_off_q;
        fetch_addr  = base_addr + row_off_cur + ADDR_WIDTH'(h_cnt_q[HW-1:1]);
    end

    // Frame latch and row offset; the offset steps after each odd active line
    // so every framebuffer row is scanned on two consecutive lines.
    always_comb begin
        fb_latched_d = fb_latched_q;
        row_off_d    = row_off_q;
        if (frame_top) begin
            fb_latched_d = fbHDMI;
            row_off_d    = '0;
        end else if (h_wrap && v_cnt_q[0] && (v_cnt_q < V_LAST_ACT)) begin
            row_off_d = row_off_q + ROW_STEP;
        end
    end

    // Memory request stage; the address holds while no read is issued.
    always_comb begin
        mem_read_d    = act;
        mem_addr_d    = act ? fetch_addr : mem_addr_q;
        frame_start_d = frame_top;
    end

    // Timing delay lines matching the memory read path.
    always_comb begin
        act_dly_d = {act_dly_q[L-2:0], act};
        hs_dly_d  = {hs_dly_q[L-2:0], hs};
        vs_dly_d  = {vs_dly_q[L-2:0], vs};
    end

    // RGB565 to RGB888 by MSB replication; blanked outside the active region.
    always_comb begin
        rgb_d = '0;
        if (act_dly_q[L-2]) begin
            rgb_d = {memData[15:11], memData[15:13],
                     memData[10:5],  memData[10:9],
                     memData[4:0],   memData[4:2]};
        end
    end

    // State register for counters, latch and row offset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            fb_latched_q <= 1'b0;
            row_off_q    <= '0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            fb_latched_q <= fb_latched_d;
            row_off_q    <= row_off_d;
        end
    end

    // Pipeline registers feeding memory and the output pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_q    <= '0;
            mem_read_q    <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
            act_dly_q     <= '0;
            hs_dly_q      <= '0;
            vs_dly_q      <= '0;
        end else begin
            mem_addr_q    <= mem_addr_d;
            mem_read_q    <= mem_read_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
            act_dly_q     <= act_dly_d;
            hs_dly_q      <= hs_dly_d;
            vs_dly_q      <= vs_dly_d;
        end
    end

    assign memAddr    = mem_addr_q;
    assign memRead    = mem_read_q;
    assign frameStart = frame_start_q;
    assign rgb        = rgb_q;
    assign de         = act_dly_q[L-1];
    assign hSync      = hs_dly_q[L-1];
    assign vSync      = vs_dly_q[L-1];

endmodule

// File: tb/tb_hdmi_scanout.sv
// Bench for hdmi_scanout: directed vector tables on a full-size instance plus a
// cycle-by-cycle model check of a shrunken-timing instance with READ_LATENCY=2.
module tb_hdmi_scanout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance.
    logic        reset, fbHDMI;
    logic [15:0] memData;
    logic [16:0] memAddr;
    logic        memRead, de, hSync, vSync, frameStart;
    logic [23:0] rgb;

    // Small-timing instance.
    logic        rst_s, fb_s;
    logic [15:0] memData_s, d1_s;
    logic [16:0] memAddr_s;
    logic        memRead_s, de_s, hSync_s, vSync_s, frameStart_s;
    logic [23:0] rgb_s;

    hdmi_scanout u_dut (
        .clk        (clk),
        .reset      (reset),
        .fbHDMI     (fbHDMI),
        .memData    (memData),
        .memAddr    (memAddr),
        .memRead    (memRead),
        .rgb        (rgb),
        .de         (de),
        .hSync      (hSync),
        .vSync      (vSync),
        .frameStart (frameStart)
    );

    hdmi_scanout #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .FB_WIDTH(4), .ADDR_WIDTH(17), .FB_BASE0(100), .FB_BASE1(200),
        .READ_LATENCY(2)
    ) u_small (
        .clk        (clk),
        .reset      (rst_s),
        .fbHDMI     (fb_s),
        .memData    (memData_s),
        .memAddr    (memAddr_s),
        .memRead    (memRead_s),
        .rgb        (rgb_s),
        .de         (de_s),
        .hSync      (hSync_s),
        .vSync      (vSync_s),
        .frameStart (frameStart_s)
    );

    function automatic logic [15:0] lut(input logic [1:0] a);
        case (a)
            2'd0:    return 16'hF800;
            2'd1:    return 16'h07E0;
            2'd2:    return 16'h001F;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [23:0] c565(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    // Memory models: latency 1 for the full-size instance, 2 for the small one.
    always @(posedge clk) memData <= lut(memAddr[1:0]);
    always @(posedge clk) begin
        d1_s      <= lut(memAddr_s[1:0]);
        memData_s <= d1_s;
    end

    typedef struct {
        int          cyc;
        logic [16:0] addr;
        logic        rd;
        logic        de;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   split;

    function automatic vec_t mk(int c, int a, bit r, bit d, int col, bit h, bit f);
        vec_t v;
        v.cyc  = c;
        v.addr = 17'(a);
        v.rd   = r;
        v.de   = d;
        v.rgb  = 24'(col);
        v.hs   = h;
        v.vs   = 1'b0;
        v.fs   = f;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        n_vec++;
        if (memAddr !== v.addr || memRead !== v.rd || de !== v.de || rgb !== v.rgb ||
            hSync !== v.hs || vSync !== v.vs || frameStart !== v.fs) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got addr=%0d rd=%0b de=%0b rgb=%06h hs=%0b vs=%0b fs=%0b; want addr=%0d rd=%0b de=%0b rgb=%06h hs=%0b vs=%0b fs=%0b",
                     tag, v.cyc, memAddr, memRead, de, rgb, hSync, vSync, frameStart,
                     v.addr, v.rd, v.de, v.rgb, v.hs, v.vs, v.fs);
        end
    endtask

    task automatic run_vecs(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            while (cyc < vt[i].cyc) step();
            check_vec(tag, vt[i]);
        end
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if (memAddr !== '0 || memRead !== 1'b0 || de !== 1'b0 || rgb !== '0 ||
            hSync !== 1'b0 || vSync !== 1'b0 || frameStart !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got addr=%0d rd=%0b de=%0b rgb=%06h hs=%0b vs=%0b fs=%0b; want all 0",
                     tag, memAddr, memRead, de, rgb, hSync, vSync, frameStart);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Small-instance reference: 16 clocks/line, 10 lines/frame, 160 clocks/frame.
    function automatic bit s_act(int idx);
        int i = idx % 160;
        return ((i % 16) < 8) && ((i / 16) < 6);
    endfunction

    function automatic int s_addr(int idx);
        int i = idx % 160;
        int base = (idx / 160 == 0) ? 100 : 200;
        return base + ((i / 16) / 2) * 4 + (i % 16) / 2;
    endfunction

    initial begin
        int          exp_addr, k, a, h, v;
        int          de_cnt, hs_cnt, vs_cnt, fs_cnt, rises, rise1, rise2, max_a, min_a;
        logic        prev_vs, e_rd, e_de, e_hs, e_vs, e_fs;
        logic [23:0] e_rgb;

        reset  = 1'b0;
        fbHDMI = 1'b0;
        rst_s  = 1'b0;
        fb_s   = 1'b0;

        // fbHDMI = 0 from reset.
        vt.push_back(mk(0,    0,   0, 0, 0,        0, 0));
        vt.push_back(mk(1,    0,   1, 0, 0,        0, 1));
        vt.push_back(mk(2,    0,   1, 0, 0,        0, 0));
        vt.push_back(mk(3,    1,   1, 1, 'hFF0000, 0, 0));
        vt.push_back(mk(4,    1,   1, 1, 'hFF0000, 0, 0));
        vt.push_back(mk(5,    2,   1, 1, 'h00FF00, 0, 0));
        vt.push_back(mk(7,    3,   1, 1, 'h0000FF, 0, 0));
        vt.push_back(mk(9,    4,   1, 1, 'hFFFFFF, 0, 0));
        vt.push_back(mk(11,   5,   1, 1, 'hFF0000, 0, 0));
        vt.push_back(mk(640,  319, 1, 1, 'h0000FF, 0, 0));
        vt.push_back(mk(641,  319, 0, 1, 'hFFFFFF, 0, 0));
        vt.push_back(mk(642,  319, 0, 1, 'hFFFFFF, 0, 0));
        vt.push_back(mk(643,  319, 0, 0, 0,        0, 0));
        vt.push_back(mk(658,  319, 0, 0, 0,        0, 0));
        vt.push_back(mk(659,  319, 0, 0, 0,        1, 0));
        vt.push_back(mk(754,  319, 0, 0, 0,        1, 0));
        vt.push_back(mk(755,  319, 0, 0, 0,        0, 0));
        vt.push_back(mk(801,  0,   1, 0, 0,        0, 0));
        vt.push_back(mk(803,  1,   1, 1, 'hFF0000, 0, 0));
        vt.push_back(mk(1601, 320, 1, 0, 0,        0, 0));
        vt.push_back(mk(1603, 321, 1, 1, 'hFF0000, 0, 0));
        vt.push_back(mk(1606, 322, 1, 1, 'h00FF00, 0, 0));
        split = vt.size();
        // fbHDMI = 1 at reset release, dropped to 0 after the first fetch.
        vt.push_back(mk(0,    0,     0, 0, 0,        0, 0));
        vt.push_back(mk(1,    76800, 1, 0, 0,        0, 1));
        vt.push_back(mk(2,    76800, 1, 0, 0,        0, 0));
        vt.push_back(mk(3,    76801, 1, 1, 'hFF0000, 0, 0));
        vt.push_back(mk(5,    76802, 1, 1, 'h00FF00, 0, 0));
        vt.push_back(mk(640,  77119, 1, 1, 'h0000FF, 0, 0));
        vt.push_back(mk(641,  77119, 0, 1, 'hFFFFFF, 0, 0));
        vt.push_back(mk(801,  76800, 1, 0, 0,        0, 0));
        vt.push_back(mk(802,  76800, 1, 0, 0,        0, 0));
        vt.push_back(mk(803,  76801, 1, 1, 'hFF0000, 0, 0));
        vt.push_back(mk(1601, 77120, 1, 0, 0,        0, 0));
        vt.push_back(mk(1603, 77121, 1, 1, 'hFF0000, 0, 0));

        repeat (3) @(negedge clk);
        check_zero("in_reset");
        reset = 1'b1;
        cyc   = 0;
        run_vecs("fb0", 0, split - 1);

        // Mid-frame asynchronous reset at h=300, v=2.
        while (cyc < 1900) step();
        check_int("pre_reset_rd", int'(memRead), 1);
        check_int("pre_reset_de", int'(de), 1);
        check_int("pre_reset_addr", int'(memAddr), 469);
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(negedge clk);
        check_zero("held_reset");
        fbHDMI = 1'b1;
        reset  = 1'b1;
        cyc    = 0;
        run_vecs("fb1", split, split + 1);
        fbHDMI = 1'b0;
        run_vecs("fb1", split + 2, vt.size() - 1);

        // Small instance: full model over two frames, fb select toggled mid-frame 0.
        exp_addr = 0;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        rises = 0; rise1 = -1; rise2 = -1; max_a = 0; min_a = 1 << 20;
        prev_vs = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        for (int n = 1; n <= 320; n++) begin
            @(posedge clk);
            @(negedge clk);
            e_rd = s_act(n - 1);
            if (e_rd) exp_addr = s_addr(n - 1);
            e_fs = ((n - 1) % 160 == 0);
            k = n - 4;
            e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = '0;
            if (k >= 0) begin
                h    = (k % 160) % 16;
                v    = (k % 160) / 16;
                e_de = s_act(k);
                e_hs = (h >= 10) && (h < 13);
                e_vs = (v >= 7) && (v < 9);
                if (e_de) begin
                    a     = s_addr(k);
                    e_rgb = c565(lut(a[1:0]));
                end
            end
            n_vec++;
            if (memRead_s !== e_rd || memAddr_s !== 17'(exp_addr) || de_s !== e_de ||
                rgb_s !== e_rgb || hSync_s !== e_hs || vSync_s !== e_vs ||
                frameStart_s !== e_fs) begin
                n_err++;
                $display("FAIL small cyc=%0d: got addr=%0d rd=%0b de=%0b rgb=%06h hs=%0b vs=%0b fs=%0b; want addr=%0d rd=%0b de=%0b rgb=%06h hs=%0b vs=%0b fs=%0b",
                         n, memAddr_s, memRead_s, de_s, rgb_s, hSync_s, vSync_s, frameStart_s,
                         exp_addr, e_rd, e_de, e_rgb, e_hs, e_vs, e_fs);
            end
            de_cnt += int'(de_s);
            hs_cnt += int'(hSync_s);
            vs_cnt += int'(vSync_s);
            fs_cnt += int'(frameStart_s);
            if (vSync_s && !prev_vs) begin
                rises++;
                if (rise1 < 0) rise1 = n;
                else if (rise2 < 0) rise2 = n;
            end
            prev_vs = vSync_s;
            if (memRead_s) begin
                if (int'(memAddr_s) > max_a) max_a = int'(memAddr_s);
                if (int'(memAddr_s) < min_a) min_a = int'(memAddr_s);
            end
            if (n == 50) fb_s = 1'b1;
        end
        check_int("small_de_count", de_cnt, 96);
        check_int("small_hs_count", hs_cnt, 60);
        check_int("small_vs_count", vs_cnt, 64);
        check_int("small_vs_rises", rises, 2);
        check_int("small_vs_rise1", rise1, 116);
        check_int("small_vs_period", rise2 - rise1, 160);
        check_int("small_fs_count", fs_cnt, 2);
        check_int("small_max_addr", max_a, 211);
        check_int("small_min_addr", min_a, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hdmi_scanout.md
Name: hdmi_scanout

Overview:
Downstream consumer of the buffer controller's fbHDMI select. Generates 640x480 video timing and fetches pixels from the display framebuffer in RAM. Scans a 320x240 RGB565 framebuffer at 2x scale and emits aligned RGB888, DE, hSync and vSync. vSync feeds back to the buffer controller as its vSync input.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch
FB_WIDTH, 320, framebuffer pixels per row (= H_ACTIVE/2)
ADDR_WIDTH, 17, framebuffer word address width
FB_BASE0, 0, word base address of framebuffer 0
FB_BASE1, 76800, word base address of framebuffer 1
READ_LATENCY, 1, clocks from memAddr/memRead to valid memData (>=1)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset (0 = reset)
fbHDMI  in  1  framebuffer to display (0 -> FB_BASE0, 1 -> FB_BASE1)
memData  in  16  RGB565 read data, valid READ_LATENCY clocks after memRead
memAddr  out  ADDR_WIDTH  framebuffer read word address
memRead  out  1  read strobe, one word per asserted clock
rgb  out  24  RGB888 pixel {R,G,B}
de  out  1  data enable (active region)
hSync  out  1  horizontal sync, active-high
vSync  out  1  vertical sync, active-high; drives buffer controller vSync
frameStart  out  1  one-clock pulse when fb select is latched

Behaviour:
- Reset (async assert, sync release): hCount = vCount = 0. memAddr = 0, memRead = 0, rgb = 0, de = 0, hSync = 0, vSync = 0, frameStart = 0. fbLatched = 0. All delay-line stages = 0.
- Counters: H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
  - hCount increments every clk and wraps at H_TOTAL-1 -> 0.
  - vCount increments on the h wrap and wraps at V_TOTAL-1 -> 0.
- Region order per line: active [0, H_ACTIVE), then front porch, sync, back porch. The same order applies vertically.
- Stage 0 signals (combinational from counters):
  - act = h < H_ACTIVE && v < V_ACTIVE
  - hs = h in [H_ACTIVE+H_FRONT, +H_SYNC)
  - vs = v in [V_ACTIVE+V_FRONT, +V_SYNC)
- Frame latch: at h==0 && v==0, fbLatched <= fbHDMI and frameStart pulses for 1 clk (registered, same cycle as memAddr stage).
  - fbHDMI changes at any other time have no effect until the next frame.
  - fbLatched selects the base for that same (0,0) fetch.
- Address generation, incremental (no multiplier):
  - lineBase = base(fbLatched) at frame start.
  - lineBase += FB_WIDTH after every second active line (odd v -> even v+1), so each framebuffer row is shown twice.
  - Fetch address = lineBase + (h >> 1).
- memAddr/memRead are registered 1 clk after the counter cycle; memRead = act.
  - memAddr holds its last value when memRead = 0.
  - Each framebuffer word is read twice per line (adjacent h); this is accepted.
- Colour: memData is captured into rgb 1 clk after it is valid.
  - R = {d[15:11], d[15:13]}, G = {d[10:5], d[10:9]}, B = {d[4:0], d[4:2]}.
  - rgb = 0 when the delayed de = 0.
- Alignment: act, hs and vs pass through a delay line of L = READ_LATENCY+2 clks. de, hSync and vSync appear on the same clock as the rgb of that pixel, so total pipeline latency is L from counter to pins.
- vSync is high for exactly V_SYNC*H_TOTAL clks per frame (1600 at defaults) and has one rising edge per frame.
- Reset mid-frame: all outputs drop to reset values immediately (async). Counting restarts from (0,0) with a fresh latch. No partial-frame state survives.
- Bad-read boundary: at the last active pixel (639,479), fetch address = base + 76799. No address beyond base + FB_WIDTH*V_ACTIVE/2 - 1 is ever issued.

Test Plan:
- Reset release, READ_LATENCY=1 -> first memRead=1, memAddr=0 on clk 1. First de=1 with rgb from memData on clk 3. All outputs 0 while reset=0.
- Run 2 frames -> de high 640 clks/line for 480 lines. hSync high 96 clks starting at h=656. vSync rising edge every 420000 clks, high 1600 clks.
- fbHDMI=1 from reset -> first-line addresses 76800,76800,76801,76801,...,77119. Line 1 repeats them; line 2 starts at 77120.
- Toggle fbHDMI mid-frame (v=100) -> memAddr keeps the old base until the next frame. frameStart pulses once at the next (0,0); the new base is used there.
- memData 0xF800, 0x07E0, 0x001F, 0xFFFF -> rgb 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF. In blanking, rgb = 0 regardless of memData.
- Assert reset at h=300, v=200 -> outputs 0 within the same clk. After release, the sequence matches scenario 1.
